// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch (IF)
// and load/store (LS), one registered access per two cycles.
// Ports:
//   clk, rst (sync, active-low)
//   if_*  : fetch request/grant/done/rdata/err (word reads only)
//   ls_*  : load/store request with size/sign-extend, grant/done/rdata/err
//   mem_* : memory port, driven only during the ACCESS cycle
module mem_port_arbiter #(
    parameter int BUS_WIDTH     = 32,
    parameter int MEM_BYTES     = 64,
    parameter int LS_STREAK_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [BUS_WIDTH-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_done,
    output logic [BUS_WIDTH-1:0] if_rdata,
    output logic                 if_err,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [BUS_WIDTH-1:0] ls_addr,
    input  logic [BUS_WIDTH-1:0] ls_wdata,
    input  logic [1:0]           ls_size,
    input  logic                 ls_sx,
    output logic                 ls_gnt,
    output logic                 ls_done,
    output logic [BUS_WIDTH-1:0] ls_rdata,
    output logic                 ls_err,
    output logic [BUS_WIDTH-1:0] mem_addr,
    output logic [BUS_WIDTH-1:0] mem_wdata,
    output logic                 mem_wr_en,
    output logic [1:0]           mem_size,
    output logic                 mem_sz_ex,
    input  logic [BUS_WIDTH-1:0] mem_rdata
);

    localparam int SW = $clog2(LS_STREAK_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(LS_STREAK_MAX);
    localparam logic [BUS_WIDTH:0] MEM_END = (BUS_WIDTH+1)'(MEM_BYTES);

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [SW-1:0]        streak;
    logic [BUS_WIDTH-1:0] cmd_addr;
    logic [BUS_WIDTH-1:0] cmd_wdata;
    logic [1:0]           cmd_size;
    logic                 cmd_we;
    logic                 cmd_sx;
    logic                 cmd_ls;
    logic                 cmd_err;
    logic                 force_if;

    // Misalignment, illegal size, or access running past the end of memory.
    // The end address is formed one bit wider so it cannot wrap.
    function automatic logic access_fault(input logic [BUS_WIDTH-1:0] a,
                                          input logic [1:0]           sz);
        logic [2:0]         nb;
        logic [BUS_WIDTH:0] end_a;
        logic               f;
        f  = 1'b0;
        nb = 3'd1;
        unique case (sz)
            2'b10: begin
                nb = 3'd4;
                f  = (a[1:0] != 2'b00);
            end
            2'b01: begin
                nb = 3'd2;
                f  = a[0];
            end
            2'b00: nb = 3'd1;
            default: f = 1'b1;
        endcase
        end_a = {1'b0, a} + {{(BUS_WIDTH-2){1'b0}}, nb};
        if (end_a > MEM_END)
            f = 1'b1;
        return f;
    endfunction

    // IF is forced only once LS has won LS_STREAK_MAX times in a row
    // while IF was waiting.
    assign force_if = if_req && (streak == STREAK_MAX);

    always_comb begin
        state_nxt = state;
        ls_gnt    = 1'b0;
        if_gnt    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_size  = 2'b10;
        mem_sz_ex = 1'b0;
        mem_wr_en = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst) begin
                    ls_gnt = ls_req && !force_if;
                    if_gnt = if_req && !ls_gnt;
                end
                if (ls_gnt || if_gnt)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                state_nxt = IDLE;
                mem_addr  = cmd_addr;
                mem_wdata = cmd_wdata;
                mem_size  = cmd_size;
                mem_sz_ex = cmd_sx;
                mem_wr_en = cmd_we && !cmd_err && rst;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            streak    <= '0;
            cmd_addr  <= '0;
            cmd_wdata <= '0;
            cmd_size  <= 2'b00;
            cmd_we    <= 1'b0;
            cmd_sx    <= 1'b0;
            cmd_ls    <= 1'b0;
            cmd_err   <= 1'b0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            if_rdata  <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            state   <= state_nxt;
            if_done <= 1'b0;
            if_err  <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            if (ls_gnt) begin
                cmd_addr  <= ls_addr;
                cmd_wdata <= ls_wdata;
                cmd_size  <= ls_size;
                cmd_we    <= ls_we;
                cmd_sx    <= ls_sx;
                cmd_ls    <= 1'b1;
                cmd_err   <= access_fault(ls_addr, ls_size);
                if (!if_req)
                    streak <= '0;
                else if (streak != STREAK_MAX)
                    streak <= streak + 1'b1;
            end else if (if_gnt) begin
                cmd_addr  <= if_addr;
                cmd_wdata <= '0;
                cmd_size  <= 2'b10;
                cmd_we    <= 1'b0;
                cmd_sx    <= 1'b0;
                cmd_ls    <= 1'b0;
                cmd_err   <= access_fault(if_addr, 2'b10);
                streak    <= '0;
            end
            if (state == ACCESS) begin
                if (cmd_ls) begin
                    ls_done  <= 1'b1;
                    ls_err   <= cmd_err;
                    ls_rdata <= (cmd_we || cmd_err) ? '0 : mem_rdata;
                end else begin
                    if_done  <= 1'b1;
                    if_err   <= cmd_err;
                    if_rdata <= cmd_err ? '0 : mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a
// 64-byte behavioural memory (combinational read, negedge write).
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_done;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [1:0]  ls_size;
    logic        ls_sx;
    logic        ls_gnt;
    logic        ls_done;
    logic [31:0] ls_rdata;
    logic        ls_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr_en;
    logic [1:0]  mem_size;
    logic        mem_sz_ex;
    logic [31:0] mem_rdata;

    logic [7:0]  mem [0:63];
    logic [5:0]  ra;
    logic [32:0] rd_end;
    int          n_tests = 0;
    int          n_fail = 0;
    int          wr_count = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .BUS_WIDTH(32),
        .MEM_BYTES(64),
        .LS_STREAK_MAX(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .if_req(if_req),
        .if_addr(if_addr),
        .if_gnt(if_gnt),
        .if_done(if_done),
        .if_rdata(if_rdata),
        .if_err(if_err),
        .ls_req(ls_req),
        .ls_we(ls_we),
        .ls_addr(ls_addr),
        .ls_wdata(ls_wdata),
        .ls_size(ls_size),
        .ls_sx(ls_sx),
        .ls_gnt(ls_gnt),
        .ls_done(ls_done),
        .ls_rdata(ls_rdata),
        .ls_err(ls_err),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_wr_en(mem_wr_en),
        .mem_size(mem_size),
        .mem_sz_ex(mem_sz_ex),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [32:0] nbytes(input logic [1:0] sz);
        case (sz)
            2'b10:   return 33'd4;
            2'b01:   return 33'd2;
            default: return 33'd1;
        endcase
    endfunction

    always_comb begin
        mem_rdata = '0;
        ra        = mem_addr[5:0];
        rd_end    = {1'b0, mem_addr} + nbytes(mem_size);
        if (rd_end <= 33'd64) begin
            case (mem_size)
                2'b10: mem_rdata = {mem[ra+6'd3], mem[ra+6'd2],
                                    mem[ra+6'd1], mem[ra]};
                2'b01: mem_rdata = {{16{mem_sz_ex & mem[ra+6'd1][7]}},
                                    mem[ra+6'd1], mem[ra]};
                2'b00: mem_rdata = {{24{mem_sz_ex & mem[ra][7]}}, mem[ra]};
                default: mem_rdata = '0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mem_wr_en) begin
            wr_count <= wr_count + 1;
            if ({1'b0, mem_addr} + nbytes(mem_size) <= 33'd64) begin
                mem[mem_addr[5:0]] <= mem_wdata[7:0];
                if (mem_size != 2'b00)
                    mem[mem_addr[5:0]+6'd1] <= mem_wdata[15:8];
                if (mem_size == 2'b10) begin
                    mem[mem_addr[5:0]+6'd2] <= mem_wdata[23:16];
                    mem[mem_addr[5:0]+6'd3] <= mem_wdata[31:24];
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic ls_xact(input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size,
                           input logic sx, output logic [31:0] rd,
                           output logic err, output int lat);
        int cyc;
        rd  = '0;
        err = 1'b0;
        lat = -1;
        @(posedge clk);
        #1;
        ls_req   = 1'b1;
        ls_we    = we;
        ls_addr  = addr;
        ls_wdata = wdata;
        ls_size  = size;
        ls_sx    = sx;
        cyc      = 0;
        @(negedge clk);
        while (!ls_gnt && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!ls_gnt) begin
            check("ls_gnt_timeout", ls_gnt, 1);
            ls_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 ls_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (ls_done) begin
                lat = i;
                rd  = ls_rdata;
                err = ls_err;
                break;
            end
        end
    endtask

    task automatic if_xact(input logic [31:0] addr, output logic [31:0] rd,
                           output logic err, output int lat);
        int cyc;
        rd  = '0;
        err = 1'b0;
        lat = -1;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = addr;
        cyc     = 0;
        @(negedge clk);
        while (!if_gnt && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!if_gnt) begin
            check("if_gnt_timeout", if_gnt, 1);
            if_req = 1'b0;
            return;
        end
        @(posedge clk);
        #1 if_req = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (if_done) begin
                lat = i;
                rd  = if_rdata;
                err = if_err;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat;
        int          w0;
        int          ng;
        int          both;
        logic [9:0]  seq;
        logic        seen;

        for (int i = 0; i < 64; i++)
            mem[i] = 8'h00;
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
        mem[8] = 8'h6F; mem[9] = 8'hF0; mem[10] = 8'h9F; mem[11] = 8'hFF;

        // reset held with both requests pending
        rst      = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h8;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h0;
        ls_wdata = 32'hFFFF_FFFF;
        ls_size  = 2'b10;
        ls_sx    = 1'b0;
        @(posedge clk);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_if_gnt", if_gnt, 0);
            check("rst_ls_gnt", ls_gnt, 0);
            check("rst_wr_en", mem_wr_en, 0);
            check("rst_done", {if_done, ls_done, if_err, ls_err}, 0);
            check("rst_if_rdata", if_rdata, 0);
            check("rst_ls_rdata", ls_rdata, 0);
            check("rst_mem_addr", mem_addr, 0);
            check("rst_mem_size", mem_size, 2'b10);
            if (c < 2) @(posedge clk);
        end
        @(posedge clk);
        #1;
        rst    = 1'b1;
        if_req = 1'b0;
        ls_req = 1'b0;
        check("rst_wr_count", wr_count, 0);

        // IF read
        if_xact(32'h8, rd, err, lat);
        check("if_rd_data", rd, 32'hFF9F_F06F);
        check("if_rd_err", err, 0);
        check("if_rd_lat", lat, 2);
        if_xact(32'h6, rd, err, lat);
        check("if_mis_err", err, 1);
        check("if_mis_data", rd, 0);

        // simultaneous requests: LS first, IF granted alongside ls_done
        @(posedge clk);
        #1;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h10;
        ls_wdata = 32'h1234_56A5;
        ls_size  = 2'b00;
        ls_sx    = 1'b0;
        if_req   = 1'b1;
        if_addr  = 32'h8;
        @(negedge clk);
        check("both_ls_gnt", ls_gnt, 1);
        check("both_if_gnt", if_gnt, 0);
        @(posedge clk);
        #1 ls_req = 1'b0;
        @(negedge clk);
        check("both_access_gnt", {ls_gnt, if_gnt}, 0);
        check("both_wr_en", mem_wr_en, 1);
        @(negedge clk);
        check("both_ls_done", ls_done, 1);
        check("both_ls_err", ls_err, 0);
        check("both_ls_rdata", ls_rdata, 0);
        check("both_if_gnt2", if_gnt, 1);
        check("both_if_nodone", if_done, 0);
        @(posedge clk);
        #1 if_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("both_if_done", if_done, 1);
        check("both_if_rdata", if_rdata, 32'hFF9F_F06F);
        check("sb_mem10", mem[16], 8'hA5);
        check("sb_mem11", mem[17], 8'h00);
        ls_xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b1, rd, err, lat);
        check("lb_sx", rd, 32'hFFFF_FFA5);
        check("lb_sx_lat", lat, 2);
        ls_xact(1'b0, 32'h10, 32'h0, 2'b00, 1'b0, rd, err, lat);
        check("lb_zx", rd, 32'h0000_00A5);

        // fairness with both requests held
        @(posedge clk);
        #1;
        ls_req  = 1'b1;
        ls_we   = 1'b0;
        ls_addr = 32'h0;
        ls_size = 2'b10;
        ls_sx   = 1'b0;
        if_req  = 1'b1;
        if_addr = 32'h8;
        ng      = 0;
        both    = 0;
        seq     = '0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge clk);
            if (ls_gnt && if_gnt)
                both++;
            if (ls_gnt) begin
                seq[ng] = 1'b1;
                ng++;
            end else if (if_gnt) begin
                seq[ng] = 1'b0;
                ng++;
            end
        end
        @(posedge clk);
        #1;
        ls_req = 1'b0;
        if_req = 1'b0;
        repeat (3) @(negedge clk);
        check("streak_count", ng, 10);
        check("streak_seq", {22'd0, seq}, 32'h0000_01EF);
        check("streak_both", both, 0);

        // faults: no write ever reaches memory
        w0 = wr_count;
        ls_xact(1'b1, 32'h2, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, err, lat);
        check("err_mis_w_err", err, 1);
        check("err_mis_w_lat", lat, 2);
        ls_xact(1'b1, 32'h0, 32'hDEAD_BEEF, 2'b11, 1'b0, rd, err, lat);
        check("err_sz3_err", err, 1);
        ls_xact(1'b1, 32'h40, 32'hDEAD_BEEF, 2'b10, 1'b0, rd, err, lat);
        check("err_oob_err", err, 1);
        ls_xact(1'b0, 32'h2, 32'h0, 2'b10, 1'b0, rd, err, lat);
        check("err_mis_r_err", err, 1);
        check("err_mis_r_data", rd, 0);
        ls_xact(1'b0, 32'h3F, 32'h0, 2'b01, 1'b0, rd, err, lat);
        check("err_h3f_err", err, 1);
        ls_xact(1'b0, 32'hFFFF_FFFC, 32'h0, 2'b10, 1'b0, rd, err, lat);
        check("err_wrap_err", err, 1);
        check("err_no_write", wr_count - w0, 0);
        check("err_mem0", {mem[3], mem[2], mem[1], mem[0]}, 32'h4433_2211);

        // last word / last half
        ls_xact(1'b1, 32'h3C, 32'h8765_4321, 2'b10, 1'b0, rd, err, lat);
        check("top_sw_err", err, 0);
        ls_xact(1'b0, 32'h3C, 32'h0, 2'b10, 1'b0, rd, err, lat);
        check("top_lw_data", rd, 32'h8765_4321);
        check("top_lw_err", err, 0);
        ls_xact(1'b0, 32'h3E, 32'h0, 2'b01, 1'b0, rd, err, lat);
        check("top_lhu", rd, 32'h0000_8765);
        check("top_lhu_err", err, 0);
        ls_xact(1'b0, 32'h3E, 32'h0, 2'b01, 1'b1, rd, err, lat);
        check("top_lh", rd, 32'hFFFF_8765);

        // reset during ACCESS of a store
        w0 = wr_count;
        @(posedge clk);
        #1;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h20;
        ls_wdata = 32'hCAFE_F00D;
        ls_size  = 2'b10;
        @(negedge clk);
        check("rsta_gnt", ls_gnt, 1);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        ls_req = 1'b0;
        @(negedge clk);
        check("rsta_wr_en", mem_wr_en, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (ls_done)
                seen = 1'b1;
        end
        check("rsta_no_done", seen, 0);
        check("rsta_mem", {mem[35], mem[34], mem[33], mem[32]}, 0);
        check("rsta_no_write", wr_count - w0, 0);
        if_xact(32'h8, rd, err, lat);
        check("rsta_recover", rd, 32'hFF9F_F06F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
